// File: rtl/hetic_arbiter.sv
// hetic_arbiter: priority arbitration and claim sequencer for the HETIC
// interrupt controller. Picks the highest-priority eligible line (lowest index
// on ties), offers it through a valid/ack handshake, pulses a claim back to the
// line register file and blanks the offer until the cleared pending bit has
// propagated through the arbitration tree.
// Build option: define HETIC_ARB_PIPE_EN to register the stage-1 group results
// (latency 2, blanking 3 cycles); undefined gives latency 1, blanking 2 cycles.
module hetic_arbiter #(
  parameter int unsigned NrIrqLines = 64,
  parameter int unsigned NrIrqPrios = 32,
  parameter int unsigned GroupSize  = 8,
  localparam int unsigned IrqWidth  = $clog2(NrIrqLines),
  localparam int unsigned PrioWidth = $clog2(NrIrqPrios)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NrIrqLines-1:0]           line_ie_i,
  input  logic [NrIrqLines-1:0]           line_ip_i,
  input  logic [NrIrqLines-1:0]           line_heti_i,
  input  logic [NrIrqLines-1:0]           line_nest_i,
  input  logic [NrIrqLines*PrioWidth-1:0] line_prio_i,
  input  logic [PrioWidth-1:0]            core_level_i,
  output logic                            irq_valid_o,
  output logic [IrqWidth-1:0]             irq_id_o,
  output logic [PrioWidth-1:0]            irq_level_o,
  output logic                            irq_heti_o,
  output logic                            irq_nest_o,
  input  logic                            irq_ack_i,
  output logic                            claim_valid_o,
  output logic [IrqWidth-1:0]             claim_id_o
);

  localparam int unsigned NrGroups = NrIrqLines / GroupSize;
  localparam int unsigned LocWidth = (GroupSize > 1) ? $clog2(GroupSize) : 1;
`ifdef HETIC_ARB_PIPE_EN
  localparam logic [1:0] Lat = 2'd3;
`else
  localparam logic [1:0] Lat = 2'd2;
`endif

  // Per-line priority slices and eligibility (threshold applied here only)
  logic [PrioWidth-1:0]  prio [NrIrqLines];
  logic [NrIrqLines-1:0] elig;

  for (genvar gi = 0; gi < NrIrqLines; gi++) begin : g_line
    assign prio[gi] = line_prio_i[gi*PrioWidth +: PrioWidth];
    assign elig[gi] = line_ie_i[gi] & line_ip_i[gi] & (prio[gi] > core_level_i);
  end

  // Stage-1 group results
  logic [NrGroups-1:0]  s1_any_d, s1_any_q;
  logic [NrGroups-1:0]  s1_heti_d, s1_heti_q;
  logic [NrGroups-1:0]  s1_nest_d, s1_nest_q;
  logic [LocWidth-1:0]  s1_idx_d [NrGroups];
  logic [LocWidth-1:0]  s1_idx_q [NrGroups];
  logic [PrioWidth-1:0] s1_prio_d [NrGroups];
  logic [PrioWidth-1:0] s1_prio_q [NrGroups];

  for (genvar gi = 0; gi < NrGroups; gi++) begin : g_grp
    logic                 grp_any;
    logic [LocWidth-1:0]  grp_idx;
    logic [PrioWidth-1:0] grp_prio;
    logic                 grp_heti;
    logic                 grp_nest;

    // Group winner: ascending scan with a strict compare keeps the lowest index on ties
    always_comb begin
      grp_any  = 1'b0;
      grp_idx  = '0;
      grp_prio = '0;
      grp_heti = 1'b0;
      grp_nest = 1'b0;
      for (int j = 0; j < int'(GroupSize); j++) begin
        if (elig[gi*GroupSize+j] && (!grp_any || prio[gi*GroupSize+j] > grp_prio)) begin
          grp_any  = 1'b1;
          grp_idx  = LocWidth'(j);
          grp_prio = prio[gi*GroupSize+j];
          grp_heti = line_heti_i[gi*GroupSize+j];
          grp_nest = line_nest_i[gi*GroupSize+j];
        end
      end
    end

    assign s1_any_d[gi]  = grp_any;
    assign s1_idx_d[gi]  = grp_idx;
    assign s1_prio_d[gi] = grp_prio;
    assign s1_heti_d[gi] = grp_heti;
    assign s1_nest_d[gi] = grp_nest;
  end

`ifdef HETIC_ARB_PIPE_EN
  // Register the group results so the tree is split into two register stages
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_any_q  <= '0;
      s1_heti_q <= '0;
      s1_nest_q <= '0;
      for (int g = 0; g < int'(NrGroups); g++) begin
        s1_idx_q[g]  <= '0;
        s1_prio_q[g] <= '0;
      end
    end else begin
      s1_any_q  <= s1_any_d;
      s1_heti_q <= s1_heti_d;
      s1_nest_q <= s1_nest_d;
      for (int g = 0; g < int'(NrGroups); g++) begin
        s1_idx_q[g]  <= s1_idx_d[g];
        s1_prio_q[g] <= s1_prio_d[g];
      end
    end
  end
`else
  assign s1_any_q  = s1_any_d;
  assign s1_heti_q = s1_heti_d;
  assign s1_nest_q = s1_nest_d;
  assign s1_idx_q  = s1_idx_d;
  assign s1_prio_q = s1_prio_d;
`endif

  // Stage 2: reduce group winners with the same rule (lowest group wins ties)
  logic                 s2_any;
  logic [IrqWidth-1:0]  s2_id;
  logic [PrioWidth-1:0] s2_prio;
  logic                 s2_heti;
  logic                 s2_nest;

  always_comb begin
    s2_any  = 1'b0;
    s2_id   = '0;
    s2_prio = '0;
    s2_heti = 1'b0;
    s2_nest = 1'b0;
    for (int g = 0; g < int'(NrGroups); g++) begin
      if (s1_any_q[g] && (!s2_any || s1_prio_q[g] > s2_prio)) begin
        s2_any  = 1'b1;
        s2_id   = IrqWidth'(g * int'(GroupSize)) | IrqWidth'(s1_idx_q[g]);
        s2_prio = s1_prio_q[g];
        s2_heti = s1_heti_q[g];
        s2_nest = s1_nest_q[g];
      end
    end
  end

  typedef enum logic {OFFER, BLANK} state_e;

  state_e               state_q;
  logic [1:0]           cnt_q;
  logic                 valid_q;
  logic [IrqWidth-1:0]  id_q;
  logic [PrioWidth-1:0] level_q;
  logic                 heti_q;
  logic                 nest_q;
  logic                 take_ack;

  // An ack only counts while something is actually offered
  assign take_ack = (state_q == OFFER) & irq_ack_i & valid_q;

  // Offer/blank sequencer; the last blanking cycle reloads the offer so valid
  // is low for exactly Lat cycles after the ack cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= OFFER;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
      level_q <= '0;
      heti_q  <= 1'b0;
      nest_q  <= 1'b0;
    end else begin
      case (state_q)
        OFFER: begin
          if (take_ack) begin
            state_q <= BLANK;
            cnt_q   <= Lat;
            valid_q <= 1'b0;
            id_q    <= '0;
            level_q <= '0;
            heti_q  <= 1'b0;
            nest_q  <= 1'b0;
          end else begin
            valid_q <= s2_any;
            id_q    <= s2_id;
            level_q <= s2_prio;
            heti_q  <= s2_heti;
            nest_q  <= s2_nest;
          end
        end
        default: begin
          if (cnt_q <= 2'd1) begin
            state_q <= OFFER;
            cnt_q   <= '0;
            valid_q <= s2_any;
            id_q    <= s2_id;
            level_q <= s2_prio;
            heti_q  <= s2_heti;
            nest_q  <= s2_nest;
          end else begin
            cnt_q   <= cnt_q - 2'd1;
            valid_q <= 1'b0;
            id_q    <= '0;
            level_q <= '0;
            heti_q  <= 1'b0;
            nest_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign irq_valid_o   = valid_q;
  assign irq_id_o      = id_q;
  assign irq_level_o   = level_q;
  assign irq_heti_o    = heti_q;
  assign irq_nest_o    = nest_q;
  assign claim_valid_o = take_ack;
  assign claim_id_o    = take_ack ? id_q : '0;

endmodule

// File: tb/tb_hetic_arbiter.sv
// tb_hetic_arbiter: directed scenarios followed by random traffic, checked
// every cycle against a delayed-winner reference model with claim blanking.
module tb_hetic_arbiter;

  localparam int N  = 64;
  localparam int PW = 5;
  localparam int IW = 6;
`ifdef HETIC_ARB_PIPE_EN
  localparam int LATI = 2;
  localparam int LATB = 3;
`else
  localparam int LATI = 1;
  localparam int LATB = 2;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    ie = '0, ip = '0, heti = '0, nest = '0;
  logic [N*PW-1:0] prio = '0;
  logic [PW-1:0]   level = '0;
  logic            ack = 1'b0;

  logic            irq_valid_o;
  logic [IW-1:0]   irq_id_o;
  logic [PW-1:0]   irq_level_o;
  logic            irq_heti_o;
  logic            irq_nest_o;
  logic            claim_valid_o;
  logic [IW-1:0]   claim_id_o;

  hetic_arbiter dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .line_ie_i     (ie),
    .line_ip_i     (ip),
    .line_heti_i   (heti),
    .line_nest_i   (nest),
    .line_prio_i   (prio),
    .core_level_i  (level),
    .irq_valid_o   (irq_valid_o),
    .irq_id_o      (irq_id_o),
    .irq_level_o   (irq_level_o),
    .irq_heti_o    (irq_heti_o),
    .irq_nest_o    (irq_nest_o),
    .irq_ack_i     (ack),
    .claim_valid_o (claim_valid_o),
    .claim_id_o    (claim_id_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          v;
    logic [IW-1:0] id;
    logic [PW-1:0] lvl;
    logic          h;
    logic          n;
  } offer_t;

  offer_t        pipe_q[$];
  offer_t        exp_o;
  int            blank_left;
  logic          exp_claim;
  logic [IW-1:0] exp_claim_id;
  int            n_cmp = 0;
  int            n_err = 0;

  // Winner per the arbitration rules: find the top eligible priority, then the
  // lowest line carrying it
  function automatic offer_t ref_win();
    offer_t r;
    int     top;
    int     p;
    r   = '0;
    top = 0;
    for (int k = 0; k < N; k++) begin
      p = int'(prio[k*PW +: PW]);
      if (ie[k] && ip[k] && p > int'(level) && p > top) top = p;
    end
    if (top > 0) begin
      for (int k = N - 1; k >= 0; k--) begin
        if (ie[k] && ip[k] && int'(prio[k*PW +: PW]) == top) begin
          r.v   = 1'b1;
          r.id  = IW'(k);
          r.lvl = PW'(top);
          r.h   = heti[k];
          r.n   = nest[k];
        end
      end
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    pipe_q     = {};
    for (int i = 0; i < LATI; i++) pipe_q.push_back('0);
    blank_left = 0;
    exp_claim  = 1'b0;
    exp_claim_id = '0;
  endtask

  task automatic set_line(input int k, input logic e, input logic p, input int pr);
    ie[k] = e;
    ip[k] = p;
    prio[k*PW +: PW] = PW'(pr);
  endtask

  // One clock cycle: inputs are already driven; compare at the falling edge,
  // then advance to just after the next rising edge
  task automatic cyc();
    @(negedge clk);
    exp_o = pipe_q.pop_front();
    pipe_q.push_back(ref_win());
    if (blank_left > 0) begin
      exp_o = '0;
      blank_left--;
    end
    exp_claim    = exp_o.v & ack;
    exp_claim_id = exp_claim ? exp_o.id : '0;
    check("valid", 32'(irq_valid_o), 32'(exp_o.v));
    check("id",    32'(irq_id_o),    32'(exp_o.id));
    check("level", 32'(irq_level_o), 32'(exp_o.lvl));
    check("heti",  32'(irq_heti_o),  32'(exp_o.h));
    check("nest",  32'(irq_nest_o),  32'(exp_o.n));
    check("claim_valid", 32'(claim_valid_o), 32'(exp_claim));
    if (exp_claim) check("claim_id", 32'(claim_id_o), 32'(exp_claim_id));
    $display("cyc t=%0t ack=%0b valid=%0b id=%0d lvl=%0d claim=%0b/%0d", $time, ack,
             irq_valid_o, irq_id_o, irq_level_o, claim_valid_o, claim_id_o);
    if (exp_claim) blank_left = LATB;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(irq_valid_o), 32'd0);
    check({tag, "_id"},    32'(irq_id_o),    32'd0);
    check({tag, "_level"}, 32'(irq_level_o), 32'd0);
    check({tag, "_heti"},  32'(irq_heti_o),  32'd0);
    check({tag, "_nest"},  32'(irq_nest_o),  32'd0);
    check({tag, "_claim"}, 32'(claim_valid_o), 32'd0);
    check({tag, "_cid"},   32'(claim_id_o),  32'd0);
  endtask

  initial begin
    int k;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    model_reset();

    // Single line offered
    set_line(5, 1'b1, 1'b1, 3);
    heti[5] = 1'b1;
    repeat (LATI) cyc();
    check("single_valid", 32'(irq_valid_o), 32'd1);
    check("single_id",    32'(irq_id_o),    32'd5);
    check("single_level", 32'(irq_level_o), 32'd3);
    set_line(5, 1'b0, 1'b0, 0);
    heti[5] = 1'b0;
    repeat (LATI + 1) cyc();

    // Priority tie-break, then raise line 40
    set_line(9, 1'b1, 1'b1, 7);
    set_line(40, 1'b1, 1'b1, 7);
    nest[40] = 1'b1;
    repeat (LATI) cyc();
    check("tie_id", 32'(irq_id_o), 32'd9);
    prio[40*PW +: PW] = PW'(8);
    repeat (LATI) cyc();
    check("raise_id", 32'(irq_id_o), 32'd40);
    check("raise_nest", 32'(irq_nest_o), 32'd1);
    set_line(9, 1'b0, 1'b0, 0);
    set_line(40, 1'b0, 1'b0, 0);
    nest[40] = 1'b0;
    repeat (LATI + 1) cyc();

    // Threshold filtering and priority 0
    set_line(2, 1'b1, 1'b1, 4);
    level = PW'(4);
    repeat (LATI + 1) cyc();
    check("thresh_block", 32'(irq_valid_o), 32'd0);
    level = PW'(3);
    repeat (LATI) cyc();
    check("thresh_pass_valid", 32'(irq_valid_o), 32'd1);
    check("thresh_pass_id",    32'(irq_id_o),    32'd2);
    set_line(2, 1'b0, 1'b0, 0);
    set_line(7, 1'b1, 1'b1, 0);
    level = '0;
    repeat (LATI + 1) cyc();
    check("prio0_never", 32'(irq_valid_o), 32'd0);
    set_line(7, 1'b0, 1'b0, 0);

    // Ack/claim with blanking
    set_line(12, 1'b1, 1'b1, 5);
    set_line(13, 1'b1, 1'b1, 2);
    repeat (LATI) cyc();
    check("pre_ack_id", 32'(irq_id_o), 32'd12);
    ack = 1'b1;
    #1;
    check("ack_claim_valid", 32'(claim_valid_o), 32'd1);
    check("ack_claim_id",    32'(claim_id_o),    32'd12);
    cyc();
    ack = 1'b0;
    ip[12] = 1'b0;
    for (int i = 0; i < LATB; i++) begin
      check("blank_valid", 32'(irq_valid_o), 32'd0);
      cyc();
    end
    check("reoffer_valid", 32'(irq_valid_o), 32'd1);
    check("reoffer_id",    32'(irq_id_o),    32'd13);
    repeat (3) cyc();

    // Spurious ack with nothing offered
    ip[13] = 1'b0;
    repeat (LATI + 1) cyc();
    ack = 1'b1;
    #1;
    check("spurious_claim", 32'(claim_valid_o), 32'd0);
    ip[13] = 1'b1;
    cyc();
    ack = 1'b0;
    repeat (LATI - 1) cyc();
    check("spurious_noblank", 32'(irq_valid_o), 32'd1);
    set_line(13, 1'b0, 1'b0, 0);
    repeat (LATI + 1) cyc();

    // Asynchronous reset in the middle of blanking
    set_line(20, 1'b1, 1'b1, 9);
    repeat (LATI) cyc();
    check("pre_rst_id", 32'(irq_id_o), 32'd20);
    ack = 1'b1;
    cyc();
    ack = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    repeat (LATI) cyc();
    check("post_rst_valid", 32'(irq_valid_o), 32'd1);
    check("post_rst_id",    32'(irq_id_o),    32'd20);
    set_line(20, 1'b0, 1'b0, 0);

    // Random traffic with register-file style pending clears on claim
    for (int i = 0; i < N; i++) begin
      ie[i]   = 1'($urandom);
      heti[i] = 1'($urandom);
      nest[i] = 1'($urandom);
      prio[i*PW +: PW] = PW'($urandom);
    end
    for (int c = 0; c < 400; c++) begin
      if (exp_claim) ip[exp_claim_id] = 1'b0;
      repeat (2) begin
        k = int'($urandom_range(0, N - 1));
        case ($urandom_range(0, 4))
          0, 1: ip[k] = 1'b1;
          2: ip[k] = 1'b0;
          3: prio[k*PW +: PW] = PW'($urandom);
          default: begin
            ie[k]   = 1'($urandom);
            heti[k] = 1'($urandom);
            nest[k] = 1'($urandom);
          end
        endcase
      end
      if ($urandom_range(0, 15) == 0) level = PW'($urandom_range(0, 12));
      ack = ($urandom_range(0, 3) == 0);
      cyc();
    end
    ack = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hetic_arbiter.md
# hetic_arbiter

Priority arbitration and claim sequencer for the HETIC interrupt controller. It takes the per-line enable, pending, priority and mode state held by the controller's line register file and selects the highest-priority eligible line. It presents that line to the core through a valid/ack handshake and returns a one-cycle claim to the register file so the pending bit is cleared. After each claim it blanks its output until the cleared pending bit has propagated through the arbitration pipeline.

## Interface
- `NrIrqLines`, 64: number of interrupt lines; power of two, ≥ 4.
- `NrIrqPrios`, 32: number of priority levels; power of two.
- `GroupSize`, 8: lines per first-stage group; power of two, divides `NrIrqLines`.
- `IrqWidth`, `$clog2(NrIrqLines)`: localparam.
- `PrioWidth`, `$clog2(NrIrqPrios)`: localparam.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `line_ie_i`  in  NrIrqLines  per-line enable.
- `line_ip_i`  in  NrIrqLines  per-line pending.
- `line_heti_i`  in  NrIrqLines  per-line HETI mode.
- `line_nest_i`  in  NrIrqLines  per-line nesting permitted.
- `line_prio_i`  in  NrIrqLines*PrioWidth  per-line priority; line k occupies bits [k*PrioWidth +: PrioWidth].
- `core_level_i`  in  PrioWidth  current core interrupt level (threshold).
- `irq_valid_o`  out  1  an interrupt is offered.
- `irq_id_o`  out  IrqWidth  offered line.
- `irq_level_o`  out  PrioWidth  offered priority.
- `irq_heti_o`  out  1  offered line's HETI bit.
- `irq_nest_o`  out  1  offered line's nest bit.
- `irq_ack_i`  in  1  core accepts the offer this cycle.
- `claim_valid_o`  out  1  pulse telling the register file to clear the pending bit.
- `claim_id_o`  out  IrqWidth  line to clear.

## Operation
- Eligibility: a line is eligible when `ie & ip & (prio > core_level_i)`. Priority 0 is therefore never offered.
- Arbitration: the eligible line with the highest prio wins. Equal priority resolves to the lowest index.
- Stage 1 (group): each group of `GroupSize` lines produces {any, local idx, prio}.
- Stage 2 (final): the group results are reduced with the same rule (lowest group index wins ties). The output registers hold {valid, id, prio, heti, nest}.
- `core_level_i` is applied in stage 1 only.
- FSM:
  - `OFFER` (reset state): the output registers load from the stage-2 result every cycle. The offer may change or drop while unacked; this is level semantics, and preemption by a higher line is allowed.
  - `OFFER` with `irq_ack_i & irq_valid_o` → `BLANK`. In the same cycle, `claim_valid_o`=1 and `claim_id_o`=`irq_id_o` (combinational from the registered outputs). `irq_valid_o` is forced to 0 from the next cycle.
  - `BLANK`: a counter loads `Lat` and decrements each cycle. Output registers load with valid=0. At count 0 the FSM returns to `OFFER`.
  - `Lat` = pipeline depth + 1, where +1 covers the register-file update: 3 with pipelining, 2 without.
- `irq_ack_i` while `irq_valid_o`=0 is ignored: no claim is issued and there is no state change.
- Outputs other than `irq_valid_o` are don't-care when valid=0 but are driven 0 by the registers.

## Timing
- Reset values: `irq_valid_o`=0, `irq_id_o`=0, `irq_level_o`=0, `irq_heti_o`=0, `irq_nest_o`=0, `claim_valid_o`=0, `claim_id_o`=0. FSM=`OFFER`, counter=0. All pipeline registers are cleared.
- Input-to-`irq_valid_o` latency: 2 cycles with `HETIC_ARB_PIPE_EN`, 1 cycle without.
- A claim is issued in the ack cycle. `irq_valid_o` is low for exactly `Lat` cycles after the ack cycle. It is re-offered no earlier than the cycle after that.
- Reset asserted mid-`BLANK`: everything clears immediately; no claim is issued after reset.
- `core_level_i` changes take effect with the same latency as line changes.
- Simultaneous ack and an input change in the same cycle: the claim uses the registered id, never the new winner.

## Configuration
- `HETIC_ARB_PIPE_EN` defined:
  - Stage-1 results are registered, so the tree is 2 register stages deep.
  - Latency is 2 and `Lat`=3.
- `HETIC_ARB_PIPE_EN` undefined:
  - Stage 1 feeds stage 2 combinationally, so the tree is 1 register stage deep.
  - Latency is 1 and `Lat`=2.
  - Arbitration results are otherwise identical.

## Test plan
- **Single line offered:** line 5 ie=1, ip=1, prio=3, level=0 → `irq_valid_o`=1, id=5, level=3 after the configured latency.
- **Priority tie-break:** lines 9 and 40 both prio 7 → id=9. Then raise line 40 to prio 8 → id switches to 40 within latency.
- **Threshold filtering:** line 2 prio 4 with `core_level_i`=4 → no valid. With `core_level_i`=3 → valid, id=2. Priority-0 lines are never offered.
- **Ack/claim with blanking:** ack while offering id=12 → `claim_valid_o`=1 and `claim_id_o`=12 in the same cycle. `irq_valid_o` stays 0 for `Lat` cycles. The bench clears ip[12] one cycle after the claim. Line 13 (prio 2) is offered afterwards; id 12 is never re-offered.
- **Spurious ack:** `irq_ack_i`=1 with valid=0 → no claim and no blanking.
- **Async reset during BLANK:** assert `rst_ni`=0 asynchronously → all outputs 0 immediately. After release, a pending line is offered after the normal latency.
